bitwise_arbiter: RTL and testbench

Shares one combinational BitWise logic unit (AND/OR/XOR, 32-bit) between two requesters, e.g. integer issue and CSR/atomic path. Each port uses a valid/ready request channel and a valid/ready response channel. At most one request is granted per cycle; each port has a private single-entry response register. Result is available one cycle after grant.

---
 rtl/bitwise_pkg.sv | 18 +
 rtl/BitWise.sv | 12 +
 rtl/bitwise_arbiter.sv | 105 ++++++++++
 tb/tb_bitwise_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// bitwise_pkg: shared op encoding, widths and response record for the bitwise arbiter
package bitwise_pkg;
    localparam int DATA_W    = 32;
    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [TAG_MAX_W-1:0] tag;
        logic                 err;
    } rsp_t;
endpackage

// File: rtl/BitWise.sv
// BitWise: combinational AND / OR / XOR unit shared by the arbiter ports
module BitWise
    import bitwise_pkg::*;
(
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    input  logic              iAND,
    input  logic              iORnXOR,
    output logic [DATA_W-1:0] oC
);
    assign oC = iAND ? (iA & iB) : iORnXOR ? (iA | iB) : (iA ^ iB);
endmodule

// File: rtl/bitwise_arbiter.sv
// bitwise_arbiter: two valid/ready ports sharing one BitWise unit, one grant per cycle, private response slots
// Define BITWISE_ARB_RR_EN for round-robin priority; otherwise port 0 always wins.
module bitwise_arbiter
    import bitwise_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [1:0]        iReqV,
    output logic [1:0]        oReqR,
    input  logic [DATA_W-1:0] iReqA0,
    input  logic [DATA_W-1:0] iReqB0,
    input  logic [DATA_W-1:0] iReqA1,
    input  logic [DATA_W-1:0] iReqB1,
    input  logic [1:0]        iReqOp0,
    input  logic [1:0]        iReqOp1,
    input  logic [TAG_W-1:0]  iReqTag0,
    input  logic [TAG_W-1:0]  iReqTag1,
    output logic [1:0]        oRspV,
    input  logic [1:0]        iRspR,
    output logic [DATA_W-1:0] oRspD0,
    output logic [DATA_W-1:0] oRspD1,
    output logic [TAG_W-1:0]  oRspTag0,
    output logic [TAG_W-1:0]  oRspTag1,
    output logic [1:0]        oRspErr
);
    logic [1:0]        w_elig;
    logic [1:0]        w_gnt;
    logic              w_ptr;
    logic              w_sel;
    logic              w_ill;
    op_e               w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_c;
    logic [TAG_W-1:0]  w_tag;
    rsp_t              w_rsp;
    rsp_t              r_rsp [2];
    logic [1:0]        r_full;
    logic              w_unused_tag;

    // arbitrate between eligible ports and steer the winner into the shared unit
    always_comb begin
        w_elig   = iReqV & (~r_full | iRspR);
        w_gnt[0] = ~iRst & w_elig[0] & (~w_elig[1] | ~w_ptr);
        w_gnt[1] = ~iRst & w_elig[1] & (~w_elig[0] | w_ptr);
        w_sel    = w_gnt[1];
        w_a      = w_sel ? iReqA1 : iReqA0;
        w_b      = w_sel ? iReqB1 : iReqB0;
        w_op     = op_e'(w_sel ? iReqOp1 : iReqOp0);
        w_tag    = w_sel ? iReqTag1 : iReqTag0;
        w_ill    = (w_op == OP_ILL);
        w_rsp    = '{data: w_ill ? '0 : w_c, tag: TAG_MAX_W'(w_tag), err: w_ill};
    end

    BitWise u_bitwise (
        .iA      (w_a),
        .iB      (w_b),
        .iAND    (w_op == OP_AND),
        .iORnXOR (w_op == OP_OR),
        .oC      (w_c)
    );

    // a slot fills on its transfer edge, empties on drain, and a same-cycle refill wins
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_full   <= '0;
            r_rsp[0] <= '0;
            r_rsp[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_gnt[p]) begin
                    r_full[p] <= 1'b1;
                    r_rsp[p]  <= w_rsp;
                end else if (iRspR[p]) begin
                    r_full[p] <= 1'b0;
                end
            end
        end
    end

`ifdef BITWISE_ARB_RR_EN
    logic r_ptr;

    // after any grant the losing port becomes preferred
    always_ff @(posedge iClk) begin
        if (iRst) r_ptr <= 1'b0;
        else if (|w_gnt) r_ptr <= w_gnt[0];
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    assign oReqR        = w_gnt;
    assign oRspV        = r_full;
    assign oRspD0       = r_rsp[0].data;
    assign oRspD1       = r_rsp[1].data;
    assign oRspTag0     = r_rsp[0].tag[TAG_W-1:0];
    assign oRspTag1     = r_rsp[1].tag[TAG_W-1:0];
    assign oRspErr      = {r_rsp[1].err, r_rsp[0].err};
    assign w_unused_tag = ^{r_rsp[0].tag, r_rsp[1].tag};
endmodule

// File: tb/tb_bitwise_arbiter.sv
// tb_bitwise_arbiter: directed vectors, queued expectations checked by a response monitor
module tb_bitwise_arbiter;
    localparam int TAG_W = 4;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic        e;
    } exp_t;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [1:0]  iReqV;
    logic [1:0]  oReqR;
    logic [31:0] iReqA0, iReqB0, iReqA1, iReqB1;
    logic [1:0]  iReqOp0, iReqOp1;
    logic [3:0]  iReqTag0, iReqTag1;
    logic [1:0]  oRspV;
    logic [1:0]  iRspR;
    logic [31:0] oRspD0, oRspD1;
    logic [3:0]  oRspTag0, oRspTag1;
    logic [1:0]  oRspErr;

    exp_t q0[$];
    exp_t q1[$];
    exp_t x0, x1;
    int   tests = 0;
    int   fails = 0;

    logic [1:0]  gexp [4];
    logic [31:0] sexp [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'hFFFF_FFF7,
                              32'hFFFF_FFEF, 32'hFFFF_FFDF, 32'hFFFF_FFBF, 32'hFFFF_FF7F};

    bitwise_arbiter #(.TAG_W(TAG_W)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iReqV    (iReqV),
        .oReqR    (oReqR),
        .iReqA0   (iReqA0),
        .iReqB0   (iReqB0),
        .iReqA1   (iReqA1),
        .iReqB1   (iReqB1),
        .iReqOp0  (iReqOp0),
        .iReqOp1  (iReqOp1),
        .iReqTag0 (iReqTag0),
        .iReqTag1 (iReqTag1),
        .oRspV    (oRspV),
        .iRspR    (iRspR),
        .oRspD0   (oRspD0),
        .oRspD1   (oRspD1),
        .oRspTag0 (oRspTag0),
        .oRspTag1 (oRspTag1),
        .oRspErr  (oRspErr)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge iClk);
        #1;
    endtask

    task automatic neg;
        @(negedge iClk);
    endtask

    task automatic drv0(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [3:0] t, input logic [31:0] d);
        iReqA0 = a; iReqB0 = b; iReqOp0 = op; iReqTag0 = t;
        x0 = '{d, t, op == 2'b11};
    endtask

    task automatic drv1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [3:0] t, input logic [31:0] d);
        iReqA1 = a; iReqB1 = b; iReqOp1 = op; iReqTag1 = t;
        x1 = '{d, t, op == 2'b11};
    endtask

    // pop and compare on every response handshake, then queue the expectation of any new transfer
    always @(negedge iClk) begin
        exp_t e;
        if (oRspV[0] && iRspR[0]) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL rsp0_unexpected: got data %h, expected no response", oRspD0);
            end else begin
                e = q0.pop_front();
                chk("rsp0_data", oRspD0, e.d);
                chk("rsp0_tag", oRspTag0, e.t);
                chk("rsp0_err", oRspErr[0], e.e);
            end
        end
        if (oRspV[1] && iRspR[1]) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL rsp1_unexpected: got data %h, expected no response", oRspD1);
            end else begin
                e = q1.pop_front();
                chk("rsp1_data", oRspD1, e.d);
                chk("rsp1_tag", oRspTag1, e.t);
                chk("rsp1_err", oRspErr[1], e.e);
            end
        end
        if (iReqV[0] && oReqR[0]) q0.push_back(x0);
        if (iReqV[1] && oReqR[1]) q1.push_back(x1);
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
`ifdef BITWISE_ARB_RR_EN
        gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        gexp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        iRst = 1'b1; iReqV = 2'b11; iRspR = 2'b00;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        cyc; cyc;
        neg;
        chk("rst_rspv", oRspV, 2'b00);
        chk("rst_err", oRspErr, 2'b00);
        chk("rst_d0", oRspD0, 0);
        chk("rst_d1", oRspD1, 0);
        chk("rst_tag0", oRspTag0, 0);
        chk("rst_tag1", oRspTag1, 0);
        chk("rst_reqr", oReqR, 2'b00);
        cyc;
        iReqV = 2'b00; iRst = 1'b0; iRspR = 2'b11;

        drv0(32'hF0F0_F0F0, 32'hFF00_FF00, 2'b01, 4'd3, 32'hFFF0_FFF0);
        iReqV = 2'b01;
        neg; chk("single_gnt", oReqR, 2'b01);
        cyc; iReqV = 2'b00;
        neg;
        chk("single_v", oRspV, 2'b01);
        chk("single_d", oRspD0, 32'hFFF0_FFF0);
        chk("single_tag", oRspTag0, 4'd3);
        chk("single_err", oRspErr[0], 1'b0);
        cyc;

        drv1(32'h0000_1234, 32'h0000_5678, 2'b11, 4'd5, 32'h0);
        iReqV = 2'b10;
        neg; chk("ill_gnt", oReqR, 2'b10);
        cyc; iReqV = 2'b00;
        neg;
        chk("ill_v", oRspV, 2'b10);
        chk("ill_d", oRspD1, 32'h0);
        chk("ill_err", oRspErr[1], 1'b1);
        cyc;

        drv0(32'hFFFF_0000, 32'h0F0F_0F0F, 2'b00, 4'd1, 32'h0F0F_0000);
        drv1(32'h1234_5678, 32'hFF00_FF00, 2'b00, 4'd2, 32'h1200_5600);
        iReqV = 2'b11;
        for (int i = 0; i < 4; i++) begin
            neg; chk("cont_gnt", oReqR, gexp[i]);
            cyc;
        end
        iReqV = 2'b00;
        cyc; cyc;

        iRspR = 2'b10;
        drv0(32'hAAAA_5555, 32'h0F0F_0F0F, 2'b00, 4'd7, 32'h0A0A_0505);
        iReqV = 2'b01;
        neg; chk("bp_gnt0", oReqR, 2'b01);
        cyc;
        drv0(32'h0000_0001, 32'h0000_0003, 2'b01, 4'd8, 32'h0000_0003);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drv1(32'hFFFF_FFFF, 32'h0000_FFFF, 2'b10, 4'h9, 32'hFFFF_0000);
                1: drv1(32'h1234_5678, 32'h1234_5678, 2'b10, 4'hA, 32'h0000_0000);
                default: drv1(32'h8000_0001, 32'h0000_0001, 2'b10, 4'hB, 32'h8000_0000);
            endcase
            iReqV = 2'b11;
            neg;
            chk("bp_gnt", oReqR, 2'b10);
            chk("bp_hold_d", oRspD0, 32'h0A0A_0505);
            chk("bp_hold_v", oRspV[0], 1'b1);
            cyc;
        end
        iReqV = 2'b01; iRspR = 2'b11;
        neg; chk("bp_release_gnt", oReqR, 2'b01);
        cyc; iReqV = 2'b00;
        neg;
        chk("bp_after_v", oRspV, 2'b01);
        chk("bp_after_d", oRspD0, 32'h0000_0003);
        cyc;

        for (int i = 0; i < 8; i++) begin
            drv1(32'h1 << i, 32'hFFFF_FFFF, 2'b10, 4'(i), sexp[i]);
            iReqV = 2'b10;
            neg;
            chk("stream_gnt", oReqR, 2'b10);
            if (i > 0) chk("stream_v", oRspV[1], 1'b1);
            cyc;
        end
        iReqV = 2'b00;
        neg; chk("stream_last_v", oRspV[1], 1'b1);
        cyc;
        neg; chk("stream_end_v", oRspV, 2'b00);
        cyc;

        iRspR = 2'b00;
        drv1(32'h0000_FFFF, 32'hFFFF_0000, 2'b01, 4'hC, 32'hFFFF_FFFF);
        iReqV = 2'b10;
        neg; chk("rf_gnt1", oReqR, 2'b10);
        cyc;
        drv0(32'hFFFF_FFFF, 32'h1234_5678, 2'b00, 4'hD, 32'h1234_5678);
        iReqV = 2'b01;
        neg; chk("rf_gnt0", oReqR, 2'b01);
        cyc;
        iReqV = 2'b11;
        neg;
        chk("rf_full_v", oRspV, 2'b11);
        chk("rf_nogrant", oReqR, 2'b00);
        cyc;
        iRst = 1'b1;
        q0.delete();
        q1.delete();
        neg; chk("rf_rst_reqr", oReqR, 2'b00);
        cyc;
        neg; chk("rf_rst_v", oRspV, 2'b00);
        cyc;
        iRst = 1'b0; iRspR = 2'b11;
        neg; chk("rf_first_gnt", oReqR, 2'b01);
        cyc; iReqV = 2'b00;
        neg; chk("rf_first_v", oRspV, 2'b01);
        cyc; cyc; cyc;

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
